// File: rtl/reg_file_scoreboard_if.sv
// Register-file / scoreboard bus between datapath and write-back end.
// The datapath drives addresses, write-back and issue; the block answers.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dst;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output rs_addr, rt_addr,
    output wr_en, wr_addr, wr_data,
    output iss_valid, iss_dst,
    input  rs_data, rt_data,
    input  rs_busy, rt_busy,
    input  stall, pending_cnt
  );

  modport slave (
    input  rs_addr, rt_addr,
    input  wr_en, wr_addr, wr_data,
    input  iss_valid, iss_dst,
    output rs_data, rt_data,
    output rs_busy, rt_busy,
    output stall, pending_cnt
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// MIPS register file with write-to-read bypass and a
// pending-write scoreboard for RAW/WAW stall detection.
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  reg_file_scoreboard_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_nxt;

  logic wr_hit;
  logic iss_nz;
  logic fwd_rs;
  logic fwd_rt;
  logic own_rs;
  logic own_rt;
  logic rs_busy;
  logic rt_busy;
  logic waw;
  logic stall;
  logic iss_set;

  assign wr_hit = bus.wr_en && (bus.wr_addr != '0);
  assign iss_nz = bus.iss_dst != '0;

  // Data forwarding needs a real (nonzero) write hitting the port.
  assign fwd_rs = BYPASS && wr_hit
               && (bus.wr_addr == bus.rs_addr);
  assign fwd_rt = BYPASS && wr_hit
               && (bus.wr_addr == bus.rt_addr);

  // A write-back in flight satisfies the pending read.
  assign own_rs = BYPASS && bus.wr_en
               && (bus.wr_addr == bus.rs_addr);
  assign own_rt = BYPASS && bus.wr_en
               && (bus.wr_addr == bus.rt_addr);

  // Read ports: $0 is hard zero, else bypass or storage.
  always_comb begin
    bus.rs_data = regs[bus.rs_addr];
    bus.rt_data = regs[bus.rt_addr];
    if (fwd_rs)
      bus.rs_data = bus.wr_data;
    if (fwd_rt)
      bus.rt_data = bus.wr_data;
    if (bus.rs_addr == '0)
      bus.rs_data = '0;
    if (bus.rt_addr == '0)
      bus.rt_data = '0;
  end

  // pend[0] is never set, so $0 is never busy.
  assign rs_busy = pend[bus.rs_addr] && !own_rs;
  assign rt_busy = pend[bus.rt_addr] && !own_rt;

  // WAW: the destination still has an unretired producer.
  assign waw = pend[bus.iss_dst] && iss_nz
            && !(bus.wr_en && (bus.wr_addr == bus.iss_dst));

  assign stall = bus.iss_valid
              && (rs_busy || rt_busy || waw);

  assign iss_set = bus.iss_valid && iss_nz && !stall;

  // Next pending vector: clear on write-back, then set on issue.
  always_comb begin
    pend_nxt = pend;
    if (wr_hit)
      pend_nxt[bus.wr_addr] = 1'b0;
    if (iss_set)
      pend_nxt[bus.iss_dst] = 1'b1;
  end

  // Population count of the next pending vector.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
  end

  // Register storage; $0 only ever holds the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_hit) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend  <= '0;
      cnt_q <= '0;
    end else begin
      pend  <= pend_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.rs_busy     = rs_busy;
  assign bus.rt_busy     = rt_busy;
  assign bus.stall       = stall;
  assign bus.pending_cnt = cnt_q;

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Destination end of the write-register path: consumes the RegDst-selected 5-bit write address (rt or rd), RegWrite, and write-back data.
- Holds the 32-entry MIPS register file with two combinational read ports (rs, rt) and write-to-read bypass.
- Adds a pending-write scoreboard so a future multi-cycle/pipelined datapath can stall on RAW/WAW hazards.
- Single-cycle use: tie iss_valid low; the block then behaves as a plain register file.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- wr_en  input  1  RegWrite.
- wr_addr  input  ADDR_W  write address from RegDst mux.
- wr_data  input  DATA_W  write-back data.
- iss_valid  input  1  an instruction with a register destination issues this cycle.
- iss_dst  input  ADDR_W  destination of the issuing instruction.
- rs_busy  output  1  rs has an outstanding write not satisfied this cycle.
- rt_busy  output  1  rt has an outstanding write not satisfied this cycle.
- stall  output  1  issue must be held this cycle.
- pending_cnt  output  ADDR_W+1  registered count of set pending bits.

Behaviour:
- Reset, on a clk edge with reset=1:
  - All registers are cleared to 0.
  - All pending bits are cleared to 0.
  - pending_cnt becomes 0.
  - Reset takes priority over any write or issue in the same cycle.
- Register $0:
  - Always reads 0.
  - Writes to address 0 are discarded.
  - iss_dst=0 never sets a pending bit.
- Write:
  - When wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data at the rising edge.
  - Latency: 1 edge to storage.
- Read: combinational from storage.
  - With BYPASS=1, if wr_en=1 and wr_addr==read addr and the address is nonzero, the port returns wr_data in the same cycle.
  - With BYPASS=0, the port returns the old stored value until the edge.
- Scoreboard, evaluated at each edge unless reset:
  - clear: wr_en=1 and wr_addr!=0 clears pending[wr_addr].
  - set: iss_valid=1, iss_dst!=0 and stall=0 sets pending[iss_dst].
  - Same register cleared and set in one cycle: set wins, because the new producer owns the register.
  - A stalled issue sets nothing.
- Busy, combinational:
  - rs_busy = pending[rs_addr] AND NOT (BYPASS AND wr_en AND wr_addr==rs_addr).
  - rt_busy is defined the same way on rt_addr.
  - Address 0 is never busy.
- stall, combinational:
  - stall = iss_valid AND (rs_busy OR rt_busy OR waw).
  - waw = pending[iss_dst] AND iss_dst!=0 AND NOT (wr_en AND wr_addr==iss_dst).
  - stall=0 whenever iss_valid=0.
- pending_cnt: registered popcount of the next pending vector; it is correct in the cycle after each edge.
- Write to a non-pending register: updates storage; the scoreboard is unchanged.
- All 31 pending bits set: pending_cnt=31; no overflow is possible.

Test Plan:
- Reset, then read all 32 addresses -> every rs_data/rt_data = 0; pending_cnt=0; stall=0.
- Write 0xDEADBEEF to r8; next cycle read rs=8, rt=8 -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- BYPASS=1: wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5 with rs_addr=9 in the same cycle -> rs_data=0xA5A5A5A5 before the edge. BYPASS=0 -> old value (0) until after the edge.
- Issue iss_dst=10 -> pending_cnt=1. Next cycle with iss_valid=1 and rs_addr=10 -> rs_busy=1, stall=1, pending_cnt stays 1. Writeback wr_addr=10 -> rs_busy=0 in that same cycle, stall=0, pending_cnt=0 after the edge.
- Same cycle: writeback to r5 and issue with iss_dst=5 while pending[5]=1 -> stall=0; pending[5] stays 1; pending_cnt unchanged.
- Issue r1..r31 over 31 cycles, then assert reset mid-sequence -> next cycle pending_cnt=0, all busy=0, all registers read 0.
